gshare_update_unit: RTL

- Resolution-side (writer) counterpart of the G-share predictor read path.
- Takes each resolved control-flow instruction from EX and detects misprediction.
- Issues a one-cycle-delayed front-end redirect and writes the updated 2-bit counter into the PHT.
- Owns the speculative global history register (GHR) used by fetch, plus branch/mispredict statistics counters.

---
 rtl/gshare_pkg.sv | 16 +
 rtl/sat_counter_2bit.sv | 23 ++
 rtl/gshare_update_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gshare_pkg.sv
// Shared types and constants for the G-share predictor update path.
//   pht_cnt_t     : 2-bit saturating direction counter stored in the PHT
//   SNT/WNT/WT/ST : strongly/weakly not-taken, weakly/strongly taken
//   GHR_W_DEF     : default global history length (PHT has 2**GHR_W entries)
package gshare_pkg;

  localparam int unsigned GHR_W_DEF = 8;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t SNT = 2'd0;
  localparam pht_cnt_t WNT = 2'd1;
  localparam pht_cnt_t WT  = 2'd2;
  localparam pht_cnt_t ST  = 2'd3;

endpackage

// File: rtl/sat_counter_2bit.sv
// Combinational next-state for a 2-bit saturating branch counter.
//   cnt_i   : current counter value
//   taken_i : resolved direction (1 = taken)
//   cnt_o   : counter moved one step towards the resolved direction,
//             clamped to [SNT, ST]
module sat_counter_2bit
  import gshare_pkg::*;
(
  input  pht_cnt_t cnt_i,
  input  logic     taken_i,
  output pht_cnt_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_update_unit.sv
// Resolution-side writer for the G-share predictor.
// Takes each control-flow instruction resolved in EX, detects misprediction,
// and one cycle later pulses a front-end redirect and a PHT counter write.
// Also owns the speculative GHR used by fetch and two statistics counters.
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   if_pred_valid_i/taken_i    : fetch made a branch prediction (shifts GHR)
//   ex_*                       : resolved instruction and its prediction-time
//                                GHR snapshot / PHT counter
//   ghr_o                      : speculative history for fetch indexing
//   pht_we_o/waddr_o/wdata_o   : one-cycle PHT write pulse (held when idle)
//   redirect_o/redirect_pc_o   : one-cycle flush + restart PC (held when idle)
//   br_cnt_o, mispred_cnt_o    : saturating statistics
module gshare_update_unit
  import gshare_pkg::*;
#(
  parameter int unsigned GHR_W = GHR_W_DEF,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             if_pred_valid_i,
  input  logic             if_pred_taken_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_br_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             ex_taken_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic [XLEN-1:0]  ex_pred_pc_i,
  input  logic [GHR_W-1:0] ex_ghr_i,
  input  logic [1:0]       ex_pht_cnt_i,
  output logic [GHR_W-1:0] ghr_o,
  output logic             pht_we_o,
  output logic [GHR_W-1:0] pht_waddr_o,
  output logic [1:0]       pht_wdata_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [31:0]      br_cnt_o,
  output logic [31:0]      mispred_cnt_o
);

  logic [XLEN-1:0]  next_pc;
  logic             mispred;
  logic             br_upd;
  logic [GHR_W-1:0] idx;
  pht_cnt_t         base_cnt;
  pht_cnt_t         new_cnt;

  logic             fwd_valid;
  logic [GHR_W-1:0] fwd_addr;
  pht_cnt_t         fwd_data;

  logic [GHR_W-1:0] ghr_q;
  logic [31:0]      br_q;
  logic [31:0]      mispred_q;

  // PC bits outside the index field do not participate in hashing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ex_pc_i[1:0], ex_pc_i[XLEN-1:GHR_W+2]};

  always_comb begin
    next_pc  = ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(4);
    mispred  = ex_valid_i && (next_pc != ex_pred_pc_i);
    br_upd   = ex_valid_i && ex_is_br_i;
    idx      = ex_pc_i[GHR_W+1:2] ^ ex_ghr_i;
    // The PHT read at prediction time misses a write that lands in the
    // cycle between prediction and resolution; take the last write instead.
    base_cnt = (fwd_valid && (fwd_addr == idx)) ? fwd_data : ex_pht_cnt_i;
  end

  sat_counter_2bit u_sat (
    .cnt_i   (base_cnt),
    .taken_i (ex_taken_i),
    .cnt_o   (new_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ghr_q         <= '0;
      pht_we_o      <= 1'b0;
      pht_waddr_o   <= '0;
      pht_wdata_o   <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      fwd_valid     <= 1'b0;
      fwd_addr      <= '0;
      fwd_data      <= SNT;
      br_q          <= '0;
      mispred_q     <= '0;
    end else begin
      pht_we_o   <= br_upd;
      redirect_o <= mispred;

      if (br_upd) begin
        pht_waddr_o <= idx;
        pht_wdata_o <= new_cnt;
        fwd_valid   <= 1'b1;
        fwd_addr    <= idx;
        fwd_data    <= new_cnt;
      end

      if (mispred) redirect_pc_o <= next_pc;

      // A mispredict means fetch is on the wrong path, so any fetch shift
      // this cycle is discarded in favour of the repaired history.
      if (mispred && ex_is_br_i)
        ghr_q <= {ex_ghr_i[GHR_W-2:0], ex_taken_i};
      else if (mispred)
        ghr_q <= ex_ghr_i;
      else if (if_pred_valid_i)
        ghr_q <= {ghr_q[GHR_W-2:0], if_pred_taken_i};

      if (br_upd && (br_q != '1)) br_q <= br_q + 32'd1;
      if (mispred && (mispred_q != '1)) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign ghr_o         = ghr_q;
  assign br_cnt_o      = br_q;
  assign mispred_cnt_o = mispred_q;

endmodule
